// File: rtl/uart_pkg.sv
// Shared types and register map for the memory-mapped UART transmitter.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  localparam logic [2:0] TXDATA_OFS = 3'd0;
  localparam logic [2:0] STATUS_OFS = 3'd4;

  localparam int ST_FULL   = 0;
  localparam int ST_EMPTY  = 1;
  localparam int ST_ACTIVE = 2;
  localparam int ST_OVF    = 3;

endpackage

// File: rtl/uart_fifo.sv
// Byte-wide synchronous FIFO feeding the UART shifter.
module uart_fifo #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        push,
  input  logic                        pop,
  input  logic [7:0]                  wdata,
  output logic [7:0]                  rdata,
  output logic                        full,
  output logic                        empty,
  output logic [$clog2(FIFO_DEPTH):0] count
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  assign rdata = mem[rd_ptr];
  assign full  = count == (AW+1)'(FIFO_DEPTH);
  assign empty = count == '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  // Storage needs no reset; occupancy is tracked by count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/uart_tx_mmio.sv
// 8N1 UART transmitter behind a CPU store port, with TX FIFO and status.
module uart_tx_mmio
  import uart_pkg::*;
#(
  parameter int          CLKS_PER_BIT = 868,
  parameter int          FIFO_DEPTH   = 4,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] A,
  input  logic [31:0] WD,
  output logic [31:0] RD,
  output logic        serial,
  output logic        busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic          in_win;
  logic          wr_data;
  logic          wr_stat;
  logic          push;
  logic          pop;
  logic          full;
  logic          empty;
  logic [7:0]    rdata;
  logic [AW:0]   fcount;
  logic [AW:0]   fcount_n;
  logic          overflow;
  logic          unused_wd;

  state_t        state;
  state_t        state_n;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_n;
  logic [2:0]    idx;
  logic [2:0]    idx_n;
  logic [7:0]    shift;
  logic [7:0]    shift_n;
  logic          serial_n;
  logic          bit_end;

  assign unused_wd = ^WD[31:8];

  assign in_win  = A[31:3] == BASE_ADDR[31:3];
  assign wr_data = MemWrite && in_win && A[2:0] == TXDATA_OFS;
  assign wr_stat = MemWrite && in_win && A[2:0] == STATUS_OFS;

  // A full FIFO still accepts a byte on the edge that pops one.
  assign push     = wr_data && (!full || pop);
  assign fcount_n = fcount + (AW+1)'(push) - (AW+1)'(pop);
  assign bit_end  = cnt == LAST;

  uart_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (push),
    .pop  (pop),
    .wdata(WD[7:0]),
    .rdata(rdata),
    .full (full),
    .empty(empty),
    .count(fcount)
  );

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    idx_n    = idx;
    shift_n  = shift;
    serial_n = serial;
    pop      = 1'b0;
    unique case (state)
      IDLE: begin
        serial_n = 1'b1;
        cnt_n    = '0;
        if (!empty) begin
          pop      = 1'b1;
          shift_n  = rdata;
          state_n  = START;
          serial_n = 1'b0;
        end
      end
      START: begin
        cnt_n = cnt + CW'(1);
        if (bit_end) begin
          cnt_n    = '0;
          idx_n    = '0;
          state_n  = DATA;
          serial_n = shift[0];
        end
      end
      DATA: begin
        cnt_n = cnt + CW'(1);
        if (bit_end) begin
          cnt_n = '0;
          if (idx == 3'd7) begin
            state_n  = STOP;
            serial_n = 1'b1;
          end else begin
            idx_n    = idx + 3'd1;
            shift_n  = {1'b0, shift[7:1]};
            serial_n = shift[1];
          end
        end
      end
      STOP: begin
        cnt_n = cnt + CW'(1);
        if (bit_end) begin
          cnt_n = '0;
          if (!empty) begin
            pop      = 1'b1;
            shift_n  = rdata;
            state_n  = START;
            serial_n = 1'b0;
          end else begin
            state_n  = IDLE;
            serial_n = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      idx      <= '0;
      shift    <= '0;
      serial   <= 1'b1;
      busy     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      idx    <= idx_n;
      shift  <= shift_n;
      serial <= serial_n;
      busy   <= (state_n != IDLE) || (fcount_n != '0);
      if (wr_stat)
        overflow <= 1'b0;
      else if (wr_data && full && !pop)
        overflow <= 1'b1;
    end
  end

  always_comb begin
    RD = '0;
    if (in_win && A[2:0] == STATUS_OFS) begin
      RD[ST_FULL]   = full;
      RD[ST_EMPTY]  = empty;
      RD[ST_ACTIVE] = state != IDLE;
      RD[ST_OVF]    = overflow;
    end
  end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Bench for uart_tx_mmio: frame-level reference model plus directed corners.
module tb_uart_tx_mmio;

  localparam int          CPB   = 4;
  localparam int          DEPTH = 4;
  localparam int          FLEN  = 10 * CPB;
  localparam logic [31:0] BASE  = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemWrite;
  logic [31:0] A;
  logic [31:0] WD;
  logic [31:0] RD;
  logic        serial;
  logic        busy;

  always #5 clk = ~clk;

  uart_tx_mmio #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH),
    .BASE_ADDR   (BASE)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .MemWrite(MemWrite),
    .A       (A),
    .WD      (WD),
    .RD      (RD),
    .serial  (serial),
    .busy    (busy)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Model: pending bytes, and position within the frame on the line (-1 idle).
  byte unsigned mq[$];
  int           m_pos;
  logic [7:0]   m_cur;
  bit           m_ovf;

  typedef struct {
    bit          we;
    logic [31:0] a;
    logic [31:0] exp_rd;
    bit          exp_busy;
  } vec_t;

  vec_t tbl[7];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic m_serial();
    int b;
    if (m_pos < 0) return 1'b1;
    b = m_pos / CPB;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return m_cur[b-1];
  endfunction

  function automatic logic [31:0] m_status();
    logic [31:0] s;
    s    = '0;
    s[0] = mq.size() == DEPTH;
    s[1] = mq.size() == 0;
    s[2] = m_pos >= 0;
    s[3] = m_ovf;
    return s;
  endfunction

  task automatic model_step(bit we, logic [31:0] a, logic [7:0] d);
    bit do_pop;
    bit was_full;
    do_pop   = mq.size() > 0 && (m_pos < 0 || m_pos == FLEN - 1);
    was_full = mq.size() == DEPTH;
    if (do_pop) begin
      m_cur = mq.pop_front();
      m_pos = 0;
    end else if (m_pos == FLEN - 1) begin
      m_pos = -1;
    end else if (m_pos >= 0) begin
      m_pos++;
    end
    if (we && a == BASE) begin
      if (!was_full || do_pop) mq.push_back(d);
      else m_ovf = 1'b1;
    end
    if (we && a == BASE + 4) m_ovf = 1'b0;
  endtask

  task automatic tick(bit we = 0, logic [31:0] a = BASE + 4,
                      logic [31:0] d = 0);
    MemWrite = we;
    A        = a;
    WD       = d;
    @(posedge clk);
    model_step(we, a, d[7:0]);
    #1;
    MemWrite = 1'b0;
    check("serial", serial, m_serial());
    check("busy", busy, m_pos >= 0 || mq.size() > 0);
    check("rd", RD, a == BASE + 4 ? m_status() : 32'h0);
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    MemWrite = 1'b0;
    A        = BASE + 4;
    WD       = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    mq.delete();
    m_pos = -1;
    m_ovf = 1'b0;
    check("rst_serial", serial, 1);
    check("rst_busy", busy, 0);
    check("rst_status", RD, 32'h2);
    reset = 1'b0;
  endtask

  initial begin
    logic [7:0] v;
    int guard;
    int r;
    logic [31:0] ra;

    tbl[0] = '{1'b1, BASE + 8, 32'h0, 1'b0};
    tbl[1] = '{1'b1, 32'h0,    32'h0, 1'b0};
    tbl[2] = '{1'b0, BASE + 8, 32'h0, 1'b0};
    tbl[3] = '{1'b0, 32'h0,    32'h0, 1'b0};
    tbl[4] = '{1'b0, BASE,     32'h0, 1'b0};
    tbl[5] = '{1'b0, BASE + 4, 32'h2, 1'b0};
    tbl[6] = '{1'b1, BASE + 4, 32'h2, 1'b0};

    do_reset();

    // Single 0x55 frame, line shape checked bit by bit.
    v = 8'h55;
    tick(1, BASE, 32'h55);
    check("pre_pop_high", serial, 1);
    for (int i = 0; i < FLEN; i++) begin
      tick();
      if (i < CPB)
        check("frame55", serial, 0);
      else if (i < 9 * CPB)
        check("frame55", serial, v[(i - CPB) / CPB]);
      else
        check("frame55", serial, 1);
    end
    tick();
    check("busy_fall", busy, 0);

    // Three back-to-back stores, contiguous frames.
    tick(1, BASE, 32'hA5);
    tick(1, BASE, 32'h0F);
    tick(1, BASE, 32'hF0);
    repeat (3 * FLEN + 5) tick();
    check("three_done", RD, 32'h2);

    // Overflow and its clear.
    tick(1, BASE, 32'h11);
    tick();
    tick();
    tick(1, BASE, 32'h22);
    tick(1, BASE, 32'h33);
    tick(1, BASE, 32'h44);
    tick(1, BASE, 32'h55);
    tick();
    check("full_bit", RD[0], 1);
    tick(1, BASE, 32'h66);
    tick();
    check("ovf_set", RD[3], 1);
    tick(1, BASE + 4, 32'h0);
    check("ovf_clr", RD[3], 0);
    repeat (5 * FLEN + 5) tick();
    check("ovf_drained", RD, 32'h2);

    // Decode table: out-of-window and non-register addresses.
    foreach (tbl[i]) begin
      tick(tbl[i].we, tbl[i].a, $urandom);
      check("tbl_rd", RD, tbl[i].exp_rd);
      check("tbl_busy", busy, tbl[i].exp_busy);
    end

    // Reset in the middle of data bit 3, with a second byte queued.
    tick(1, BASE, 32'h07);
    tick(1, BASE, 32'h99);
    guard = 0;
    while (m_pos != 4 * CPB + 1 && guard < 100) begin
      tick();
      guard++;
    end
    check("bit3_reached", guard < 100, 1);
    check("bit3_low", serial, 0);
    #1 reset = 1'b1;
    #1;
    check("async_serial", serial, 1);
    check("async_busy", busy, 0);
    @(posedge clk);
    #1;
    mq.delete();
    m_pos = -1;
    m_ovf = 1'b0;
    check("mid_rst_status", RD, 32'h2);
    reset = 1'b0;
    tick();
    check("flushed", busy, 0);
    tick(1, BASE, 32'h3C);
    repeat (FLEN + 3) tick();
    check("post_rst_idle", RD, 32'h2);

    // Store into a full FIFO on the STOP->START pop edge.
    tick(1, BASE, 32'hA1);
    tick();
    tick(1, BASE, 32'hB1);
    tick(1, BASE, 32'hB2);
    tick(1, BASE, 32'hB3);
    tick(1, BASE, 32'hB4);
    guard = 0;
    while (m_pos != FLEN - 1 && guard < 100) begin
      tick();
      guard++;
    end
    check("stop_reached", guard < 100, 1);
    check("full_before", RD[0], 1);
    tick(1, BASE, 32'hC5);
    tick();
    check("same_edge_ovf", RD[3], 0);
    check("same_edge_full", RD[0], 1);
    repeat (5 * FLEN + 5) tick();
    check("same_edge_drain", RD, 32'h2);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      if (r < 4) begin
        tick(1, BASE, $urandom);
      end else if (r < 5) begin
        tick(1, BASE + 4, $urandom);
      end else if (r < 7) begin
        ra = $urandom;
        tick(1, ra, $urandom);
      end else if (r < 9) begin
        tick(0, BASE, 0);
      end else begin
        tick();
      end
    end
    repeat (5 * FLEN + 5) tick();
    check("rand_drain", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
